text_grid: RTL and testbench

Parametrised multi-row character buffer for the VGA text path. It holds a `ROWS` × `COLS` grid of character codes and accepts host writes through a valid/ready port. It supports hardware scroll with automatic clearing of the exposed row. For each pixel coordinate from the VGA timing generator it returns the character code and the glyph-local pixel offsets, which feed the font ROM.

---
 rtl/text_grid.sv | 196 +++++++++++++++++++
 tb/tb_text_grid.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_grid.sv
// Character grid for the VGA text path: host writes, hardware scroll with row clear, per-pixel code lookup.
// Latency: 2 cycles from xcoor/ycoor to char_out/glyph_x/glyph_y/char_valid, one pixel per cycle in every state.
// Backpressure: wr_ready drops while a full or single-row clear runs; requests are not queued outside IDLE.
module text_grid #(
  parameter int CHAR_W  = 6,
  parameter int COLS    = 80,
  parameter int ROWS    = 4,
  parameter int CELL_W  = 8,
  parameter int CELL_H  = 10,
  parameter int X_START = 0,
  parameter int Y_START = 100,
  parameter logic [CHAR_W-1:0] BLANK = '1,
  localparam int CW  = $clog2(COLS),
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int GXW = $clog2(CELL_W),
  localparam int GYW = $clog2(CELL_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_col,
  input  logic [RW-1:0]     wr_row,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              clr_req,
  input  logic              scroll_req,
  output logic              busy,
  input  logic [9:0]        xcoor,
  input  logic [8:0]        ycoor,
  output logic [CHAR_W-1:0] char_out,
  output logic [GXW-1:0]    glyph_x,
  output logic [GYW-1:0]    glyph_y,
  output logic              char_valid
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLR_ALL = 2'd1;
  localparam logic [1:0] CLR_ROW = 2'd2;

  logic [1:0]        state;
  logic [AW-1:0]     cnt;
  logic [RW-1:0]     top_row;
  logic [RW-1:0]     clr_row;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [CHAR_W-1:0] mem_wd;

  logic [31:0]       dx;
  logic [31:0]       dy;
  logic              s1_win;
  logic [AW-1:0]     s1_addr;
  logic [GXW-1:0]    s1_gx;
  logic [GYW-1:0]    s1_gy;

  logic              win_q;
  logic [AW-1:0]     addr_q;
  logic [GXW-1:0]    gx_q;
  logic [GYW-1:0]    gy_q;

  // Logical row is rotated by top_row so a scroll never moves stored data.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] lrow,
                                              input logic [RW-1:0] top,
                                              input int col);
    int prow;
    prow = int'(lrow) + int'(top);
    if (prow >= ROWS) prow = prow - ROWS;
    return AW'(prow * COLS + col);
  endfunction

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Control FSM: clear sweeps, scroll pointer and the shared clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR_ALL;
      cnt     <= '0;
      top_row <= '0;
      clr_row <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (int'(cnt) == DEPTH - 1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        CLR_ROW: begin
          if (int'(cnt) == COLS - 1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          // A simultaneous scroll is dropped: the full clear resets top_row anyway.
          if (clr_req) begin
            state   <= CLR_ALL;
            cnt     <= '0;
            top_row <= '0;
          end else if (scroll_req) begin
            state   <= CLR_ROW;
            cnt     <= '0;
            clr_row <= top_row;
            top_row <= RW'((int'(top_row) + 1) % ROWS);
          end
        end
      endcase
    end
  end

  // Single write port: clear sweeps own it outside IDLE, host writes inside IDLE.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = BLANK;
    case (state)
      CLR_ALL: begin
        mem_we = 1'b1;
        mem_wa = cnt;
      end
      CLR_ROW: begin
        mem_we = 1'b1;
        mem_wa = AW'(int'(clr_row) * COLS + int'(cnt));
      end
      default: begin
        // Out-of-range targets still complete the handshake but store nothing.
        if (wr_valid && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS)) begin
          mem_we = 1'b1;
          mem_wa = cell_addr(wr_row, top_row, int'(wr_col));
          mem_wd = wr_char;
        end
      end
    endcase
  end

  // Grid storage; no reset, contents are defined by the clear that follows reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // S1 decode: window test and pixel-to-cell mapping using the current top_row.
  always_comb begin
    dx      = 32'(xcoor) - 32'(X_START);
    dy      = 32'(ycoor) - 32'(Y_START);
    s1_win  = (32'(xcoor) >= 32'(X_START)) && (32'(xcoor) < 32'(X_START + COLS * CELL_W)) &&
              (32'(ycoor) >= 32'(Y_START)) && (32'(ycoor) < 32'(Y_START + ROWS * CELL_H));
    s1_addr = '0;
    s1_gx   = '0;
    s1_gy   = '0;
    if (s1_win) begin
      s1_gx   = GXW'(dx % 32'(CELL_W));
      s1_gy   = GYW'(dy % 32'(CELL_H));
      s1_addr = cell_addr(RW'(dy / 32'(CELL_H)), top_row, int'(dx >> GXW));
    end
  end

  // S1 register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= 1'b0;
      addr_q <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
    end else begin
      win_q  <= s1_win;
      addr_q <= s1_addr;
      gx_q   <= s1_gx;
      gy_q   <= s1_gy;
    end
  end

  // S2 register stage: registered memory read, old data wins on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_out   <= BLANK;
      glyph_x    <= '0;
      glyph_y    <= '0;
      char_valid <= 1'b0;
    end else begin
      char_out   <= win_q ? mem[addr_q] : BLANK;
      glyph_x    <= gx_q;
      glyph_y    <= gy_q;
      char_valid <= win_q;
    end
  end

endmodule

// File: tb/tb_text_grid.sv
module tb_text_grid;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [1:0] wr_row;
  logic [5:0] wr_char;
  logic       clr_req;
  logic       scroll_req;
  logic       busy;
  logic [9:0] xcoor;
  logic [8:0] ycoor;
  logic [5:0] char_out;
  logic [2:0] glyph_x;
  logic [3:0] glyph_y;
  logic       char_valid;

  typedef struct packed {
    logic [5:0] ch;
    logic [2:0] gx;
    logic [3:0] gy;
    logic       v;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [5:0] grid [4][80];
  logic       issue = 1'b0;
  logic [1:0] pend  = 2'b00;
  int         n_tests = 0;
  int         n_fail  = 0;

  text_grid dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
    .clr_req(clr_req), .scroll_req(scroll_req), .busy(busy),
    .xcoor(xcoor), .ycoor(ycoor),
    .char_out(char_out), .glyph_x(glyph_x), .glyph_y(glyph_y), .char_valid(char_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference grid kept in logical row order; scrolls physically shift it.
  task automatic model_clear();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 80; c++) grid[r][c] = 6'h3F;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 80; c++) grid[r][c] = grid[r+1][c];
    for (int c = 0; c < 80; c++) grid[3][c] = 6'h3F;
  endtask

  function automatic exp_t exp_at(input int x, input int y);
    exp_t e;
    e.ch = 6'h3F; e.gx = 3'd0; e.gy = 4'd0; e.v = 1'b0;
    if (x < 640 && y >= 100 && y < 140) begin
      e.v  = 1'b1;
      e.ch = grid[(y - 100) / 10][x / 8];
      e.gx = 3'(x % 8);
      e.gy = 4'((y - 100) % 10);
    end
    return e;
  endfunction

  // All tasks below are entered just after a negedge and return just after one.
  task automatic issue_px(input int x, input int y);
    xcoor = 10'(x);
    ycoor = 9'(y);
    issue = 1'b1;
    exp_q.push_back(exp_at(x, y));
  endtask

  task automatic read_px(input int x, input int y);
    issue_px(x, y);
    @(negedge clk);
  endtask

  task automatic drain();
    issue = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_drain", exp_q.size(), 0);
  endtask

  task automatic write_px(input int col, input int row, input logic [5:0] ch, output int waits);
    wr_valid = 1'b1;
    wr_col   = 7'(col);
    wr_row   = 2'(row);
    wr_char  = ch;
    waits    = 0;
    while (!wr_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (!wr_ready) check("wr_timeout", 0, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    if (col < 80 && row < 4) grid[row][col] = ch;
  endtask

  task automatic count_ready_low(input string tag, input int exp);
    int n;
    n = 0;
    while (!wr_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp);
  endtask

  always @(posedge clk) pend <= {pend[0], issue};

  // Scoreboard: every output sample two edges after an issued pixel is popped and compared.
  always @(negedge clk) begin
    if (pend[1]) begin
      if (exp_q.size() == 0) begin
        check("rd_extra", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("char_out",   char_out,   mon_e.ch);
        check("glyph_x",    glyph_x,    mon_e.gx);
        check("glyph_y",    glyph_y,    mon_e.gy);
        check("char_valid", char_valid, mon_e.v);
      end
    end
  end

  initial begin
    int w;
    int bc;
    rst = 1'b1; wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0;
    clr_req = 1'b0; scroll_req = 1'b0; xcoor = '0; ycoor = '0;
    model_clear();

    @(negedge clk);
    check("rst_char_out", char_out, 6'h3F);
    check("rst_char_valid", char_valid, 0);
    check("rst_glyph_x", glyph_x, 0);
    check("rst_glyph_y", glyph_y, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    count_ready_low("init_clear_len", 320);
    check("idle_busy", busy, 0);

    read_px(8, 100);
    drain();

    write_px(5, 1, 6'h0A, w);
    check("idle_wr_wait", w, 0);
    read_px(40, 113);
    read_px(47, 113);
    read_px(0, 99);
    read_px(0, 140);
    read_px(640, 100);
    read_px(0, 139);
    read_px(639, 139);
    drain();

    // Scroll with a concurrent write that must land at the pre-scroll row.
    write_px(0, 0, 6'h01, w);
    write_px(0, 1, 6'h02, w);
    scroll_req = 1'b1;
    wr_valid = 1'b1; wr_col = 7'd1; wr_row = 2'd2; wr_char = 6'h05;
    grid[2][1] = 6'h05;
    model_scroll();
    @(negedge clk);
    scroll_req = 1'b0;
    wr_valid = 1'b0;
    bc = 0;
    issue_px(0, 100);
    while (busy && bc < 1000) begin
      if (bc == 1) issue = 1'b0;
      bc++;
      @(negedge clk);
    end
    check("scroll_busy_len", bc, 80);
    drain();
    read_px(0, 100);
    read_px(8, 110);
    read_px(40, 100);
    read_px(0, 130);
    drain();

    // Clear and scroll together: clear wins, held write waits for wr_ready.
    clr_req = 1'b1;
    scroll_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    scroll_req = 1'b0;
    model_clear();
    check("clr_busy", busy, 1);
    write_px(2, 0, 6'h07, w);
    check("clr_wr_wait", w, 320);
    read_px(16, 100);
    read_px(0, 100);
    read_px(0, 110);
    drain();

    // Reset in the middle of a full clear restarts it from address 0.
    write_px(3, 2, 6'h15, w);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    count_ready_low("rst_mid_clear_len", 320);
    read_px(24, 120);
    drain();

    // Out-of-range column: accepted, nothing stored (would alias row 1 col 0).
    write_px(80, 0, 6'h11, w);
    check("oor_wr_wait", w, 0);
    read_px(0, 110);
    read_px(632, 100);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
